rom_sum_ctrl: RTL

ROM_SUM_CTRL -- requirements
Module: rom_sum_ctrl

---
 rtl/rom_sum_ctrl_pkg.sv | 16 +
 rtl/rom_sum_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rom_sum_ctrl_pkg.sv
// Shared widths and FSM encoding for the ROM checksum controller.
package rom_sum_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROM_AW = 4;
  localparam int unsigned RAM_AW = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAcc   = 3'd1,
    StChk   = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/rom_sum_ctrl.sv
// Sums ROM words 0..N_WORDS-1, compares against the checksum word at CHK_ADDR
// and writes the sum to one RAM location, with a 4-phase start/done handshake.
module rom_sum_ctrl
  import rom_sum_ctrl_pkg::*;
#(
  parameter int unsigned N_WORDS  = 15,
  parameter int unsigned CHK_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAM_AW-1:0] ram_sel,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rw,
  output logic              ram_cs_n,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [DATA_W-1:0] sum
);

  localparam logic [ROM_AW-1:0] LastAddr = ROM_AW'(N_WORDS - 1);
  localparam logic [ROM_AW-1:0] ChkAddr  = ROM_AW'(CHK_ADDR);

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                match_q, match_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ram_rw_q, ram_rw_d;
  logic                ram_cs_n_q, ram_cs_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      sum_q      <= '0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_cs_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      sum_q      <= sum_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_rw_q   <= ram_rw_d;
      ram_cs_n_q <= ram_cs_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    sum_d      = sum_q;
    match_d    = match_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ram_rw_d   = ram_rw_q;
    ram_cs_n_d = ram_cs_n_q;

    unique case (state_q)
      StIdle: begin
        // match keeps the previous run's result until CHK overwrites it
        if (start) begin
          ram_addr_d = ram_sel;
          sum_d      = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
          ram_cs_n_d = 1'b0;
          state_d    = StAcc;
        end
      end
      StAcc: begin
        sum_d = sum_q + rom_data;
        if (rom_addr_q == LastAddr) begin
          rom_addr_d = ChkAddr;
          state_d    = StChk;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
        end
      end
      StChk: begin
        match_d  = (sum_q == rom_data);
        ram_rw_d = 1'b1;
        state_d  = StWrite;
      end
      StWrite: begin
        ram_rw_d   = 1'b0;
        busy_d     = 1'b0;
        ram_cs_n_d = 1'b1;
        done_d     = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = sum_q;
  assign ram_rw    = ram_rw_q;
  assign ram_cs_n  = ram_cs_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign sum       = sum_q;

endmodule
